// File: rtl/clk_div_multi.sv
// clk_div_multi: N-channel programmable clock divider producing registered
// divided clocks (clk_out), one-cycle ticks on each rising edge of clk_out,
// and busy flags for the ADC/DAC sampling and ANC filter-update domains.
//
// Each channel runs a phase counter. clk_out is high for div_act>>1 cycles
// and low for the remainder of the period, so odd ratios are low-biased.
// Ratio writes to a running channel are held in a shadow register and take
// effect only at a period boundary, so no period is ever truncated.
// Stopping a channel lets the current period finish before it goes idle.
//
// Optional build macro CLK_DIV_SYNC_EN adds the `sync` input. A sampled
// sync=1 restarts the period of every running or draining channel on that
// edge, which phase-aligns all channels.
module clk_div_multi #(
   parameter int N_CH        = 4,
   parameter int DIV_W       = 16,
   parameter int DIV_DEFAULT = 128,
   parameter int CH_W        = 2
) (
   input  logic              clk,
   input  logic              rst,
`ifdef CLK_DIV_SYNC_EN
   input  logic              sync,
`endif
   input  logic [N_CH-1:0]   en,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   output logic [N_CH-1:0]   clk_out,
   output logic [N_CH-1:0]   tick,
   output logic [N_CH-1:0]   busy
);

   // Per-channel control state. DRAIN means "stop requested, finishing the
   // current period".
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   logic [N_CH-1:0]  pending_vec;
   logic [DIV_W-1:0] cfg_div_c;
   logic             sync_s;

`ifdef CLK_DIV_SYNC_EN
   assign sync_s = sync;
`else
   assign sync_s = 1'b0;
`endif

   // Ratios below 2 cannot produce a clock, so they are clamped to 2.
   assign cfg_div_c = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;

   // A write is ready unless its target channel still holds an unapplied
   // ratio. Writes to non-existent channels are always accepted and dropped.
   always_comb begin
      cfg_ready = 1'b1;
      for (int i = 0; i < N_CH; i++) begin
         if (cfg_ch == CH_W'(i)) begin
            cfg_ready = ~pending_vec[i];
         end
      end
   end

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         state_t           state_q, state_d;
         logic [DIV_W-1:0] phase_q, phase_d;
         logic [DIV_W-1:0] div_act_q, div_act_d;
         logic [DIV_W-1:0] shadow_q, shadow_d;
         logic             pending_q, pending_d;
         logic             clk_q, clk_d;
         logic             tick_q, tick_d;
         logic             busy_q, busy_d;

         logic [DIV_W-1:0] half;
         logic [DIV_W-1:0] phase_inc;
         logic             wrap;
         logic             wr_hit;

         assign half      = div_act_q >> 1;
         assign phase_inc = phase_q + 1'b1;
         assign wrap      = (phase_q == div_act_q - 1'b1);
         assign wr_hit    = cfg_valid & cfg_ready & (cfg_ch == CH_W'(gi));

         // Next-state logic: start, count, wrap/restart, drain-to-idle and
         // ratio updates (direct when idle, shadowed when running).
         always_comb begin
            state_d   = state_q;
            phase_d   = phase_q;
            div_act_d = div_act_q;
            shadow_d  = shadow_q;
            pending_d = pending_q;
            clk_d     = clk_q;
            tick_d    = 1'b0;
            busy_d    = busy_q;

            case (state_q)
               ST_IDLE: begin
                  phase_d = '0;
                  clk_d   = 1'b0;
                  busy_d  = 1'b0;
                  if (en[gi]) begin
                     // Start a fresh period with its high phase.
                     state_d = ST_RUN;
                     clk_d   = 1'b1;
                     tick_d  = 1'b1;
                     busy_d  = 1'b1;
                  end
                  if (wr_hit) begin
                     div_act_d = cfg_div_c;
                  end
               end

               ST_RUN, ST_DRAIN: begin
                  if (sync_s || wrap) begin
                     // Period boundary: a shadowed ratio becomes active for
                     // the period starting now.
                     phase_d = '0;
                     if (pending_q) begin
                        div_act_d = shadow_q;
                        pending_d = 1'b0;
                     end
                     if (en[gi] || sync_s) begin
                        state_d = en[gi] ? ST_RUN : ST_DRAIN;
                        clk_d   = 1'b1;
                        tick_d  = 1'b1;
                     end else begin
                        // Stop request seen at the end of a whole period:
                        // go idle without starting another high phase.
                        state_d = ST_IDLE;
                        clk_d   = 1'b0;
                        busy_d  = 1'b0;
                     end
                  end else begin
                     phase_d = phase_inc;
                     clk_d   = (phase_inc < half);
                     state_d = en[gi] ? ST_RUN : ST_DRAIN;
                  end
                  // Running channels only pick up new ratios at a boundary;
                  // a write on the boundary edge waits for the next one.
                  if (wr_hit) begin
                     shadow_d  = cfg_div_c;
                     pending_d = 1'b1;
                  end
               end

               default: begin
                  state_d = ST_IDLE;
                  phase_d = '0;
                  clk_d   = 1'b0;
                  busy_d  = 1'b0;
               end
            endcase
         end

         // Channel state register with asynchronous active-low reset.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               state_q   <= ST_IDLE;
               phase_q   <= '0;
               div_act_q <= DIV_W'(DIV_DEFAULT);
               shadow_q  <= '0;
               pending_q <= 1'b0;
               clk_q     <= 1'b0;
               tick_q    <= 1'b0;
               busy_q    <= 1'b0;
            end else begin
               state_q   <= state_d;
               phase_q   <= phase_d;
               div_act_q <= div_act_d;
               shadow_q  <= shadow_d;
               pending_q <= pending_d;
               clk_q     <= clk_d;
               tick_q    <= tick_d;
               busy_q    <= busy_d;
            end
         end

         assign clk_out[gi]     = clk_q;
         assign tick[gi]        = tick_q;
         assign busy[gi]        = busy_q;
         assign pending_vec[gi] = pending_q;
      end
   endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Testbench for clk_div_multi: directed scenarios plus a short pseudo-random
// soak, each cycle compared against a period-level behavioural model.
module tb_clk_div_multi;
   localparam int N_CH        = 4;
   localparam int DIV_W       = 16;
   localparam int DIV_DEFAULT = 128;
   localparam int CH_W        = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [N_CH-1:0]   en = '0;
   logic              cfg_valid = 1'b0;
   logic              cfg_ready;
   logic [CH_W-1:0]   cfg_ch = '0;
   logic [DIV_W-1:0]  cfg_div = '0;
   logic [N_CH-1:0]   clk_out;
   logic [N_CH-1:0]   tick;
   logic [N_CH-1:0]   busy;
`ifdef CLK_DIV_SYNC_EN
   logic              sync = 1'b0;
`endif

   always #5 clk = ~clk;

   clk_div_multi #(
      .N_CH(N_CH), .DIV_W(DIV_W), .DIV_DEFAULT(DIV_DEFAULT), .CH_W(CH_W)
   ) dut (
      .clk(clk),
      .rst(rst),
`ifdef CLK_DIV_SYNC_EN
      .sync(sync),
`endif
      .en(en),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch),
      .cfg_div(cfg_div),
      .clk_out(clk_out),
      .tick(tick),
      .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   // Model: per channel, whether it is running, how far into the current
   // period it is, the active ratio and any queued ratio.
   bit          m_on   [N_CH];
   int          m_pos  [N_CH];
   int          m_act  [N_CH];
   int          m_shd  [N_CH];
   bit          m_pend [N_CH];
   bit          e_clk  [N_CH];
   bit          e_tick [N_CH];
   logic [63:0] hist   [N_CH];
   int          tick_cnt [N_CH];
   int          hi_cnt   [N_CH];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < N_CH; c++) begin
         m_on[c] = 0; m_pos[c] = 0; m_act[c] = DIV_DEFAULT; m_shd[c] = 0;
         m_pend[c] = 0; e_clk[c] = 0; e_tick[c] = 0;
         hist[c] = '0; tick_cnt[c] = 0; hi_cnt[c] = 0;
      end
   endtask

   function automatic bit exp_ready();
      int idx = int'(cfg_ch);
      if (idx >= N_CH) return 1'b1;
      return !m_pend[idx];
   endfunction

   // Advance the model by one clock edge using the inputs sampled there.
   task automatic model_edge(input bit acc, input bit sv);
      int wc = int'(cfg_ch);
      int wv = (cfg_div < 2) ? 2 : int'(cfg_div);
      for (int c = 0; c < N_CH; c++) begin
         bit was_on = m_on[c];
         if (!m_on[c]) begin
            if (en[c]) begin
               m_on[c] = 1; m_pos[c] = 0; e_clk[c] = 1; e_tick[c] = 1;
            end else begin
               e_clk[c] = 0; e_tick[c] = 0;
            end
         end else if (sv || m_pos[c] == m_act[c] - 1) begin
            if (m_pend[c]) begin
               m_act[c] = m_shd[c]; m_pend[c] = 0;
            end
            m_pos[c] = 0;
            if (en[c] || sv) begin
               e_clk[c] = 1; e_tick[c] = 1;
            end else begin
               m_on[c] = 0; e_clk[c] = 0; e_tick[c] = 0;
            end
         end else begin
            m_pos[c]  = m_pos[c] + 1;
            e_clk[c]  = (m_pos[c] < m_act[c] / 2);
            e_tick[c] = 0;
         end
         if (acc && wc == c) begin
            if (was_on) begin
               m_shd[c] = wv; m_pend[c] = 1;
            end else begin
               m_act[c] = wv;
            end
         end
      end
   endtask

   // One clock cycle: check cfg_ready before the edge, then every output
   // after it. An accepted write is withdrawn automatically.
   task automatic step();
      bit acc;
      bit sv;
      #1;
      check("cfg_ready", cfg_ready, exp_ready());
      acc = cfg_valid && exp_ready();
`ifdef CLK_DIV_SYNC_EN
      sv = sync;
`else
      sv = 1'b0;
`endif
      @(posedge clk);
      model_edge(acc, sv);
      #1;
      for (int c = 0; c < N_CH; c++) begin
         check($sformatf("clk_out[%0d]", c), clk_out[c], e_clk[c]);
         check($sformatf("tick[%0d]", c), tick[c], e_tick[c]);
         check($sformatf("busy[%0d]", c), busy[c], m_on[c]);
         hist[c] = {hist[c][62:0], clk_out[c]};
         if (tick[c])    tick_cnt[c]++;
         if (clk_out[c]) hi_cnt[c]++;
      end
      if (acc) cfg_valid = 1'b0;
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic write_cfg(input int ch, input int div);
      cfg_valid = 1'b1;
      cfg_ch    = CH_W'(ch);
      cfg_div   = DIV_W'(div);
   endtask

   // Assert reset asynchronously, check the reset values, release on a
   // falling edge.
   task automatic do_reset();
      cfg_valid = 1'b0;
      rst = 1'b0;
      #1;
      model_reset();
      check("reset clk_out", clk_out, 0);
      check("reset tick", tick, 0);
      check("reset busy", busy, 0);
      check("reset cfg_ready", cfg_ready, 1);
      @(posedge clk);
      #1;
      check("reset hold busy", busy, 0);
      check("reset hold clk_out", clk_out, 0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      #2;

      // Scenario 1: default ratio 128 on channel 0.
      en = 4'b0001;
      do_reset();
      steps(128);
      check("ch0 high cycles in period", hi_cnt[0], 64);
      check("ch0 ticks first period", tick_cnt[0], 1);
      steps(129);
      check("ch0 ticks after 257 cycles", tick_cnt[0], 3);
      check("ch1 idle high cycles", hi_cnt[1], 0);
      $display("scenario default ratio done: checks=%0d", checks);

      // Scenario 2: ratio 5 on channel 1 gives 2 high, 3 low.
      write_cfg(1, 5);
      step();
      en = 4'b0011;
      steps(10);
      check("ch1 div5 pattern", hist[1][9:0], 10'b1100011000);
      $display("scenario odd ratio done: checks=%0d", checks);

      // Scenario 3: reset mid-period, then shadowed ratio changes.
      en = 4'b0000;
      rst = 1'b0;
      #1;
      model_reset();
      check("mid reset clk_out", clk_out, 0);
      check("mid reset busy", busy, 0);
      check("mid reset tick", tick, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      rst = 1'b1;
      write_cfg(0, 8);
      step();
      en = 4'b0001;
      steps(4);
      write_cfg(0, 4);
      step();
      write_cfg(0, 6);
      steps(13);
      check("ch0 8->4->6 pattern", hist[0][12:0], 13'b0001100111000);
      $display("scenario shadow ratio done: checks=%0d", checks);

      // Scenario 4: stop drain and seamless restart.
      en = 4'b0000;
      do_reset();
      write_cfg(0, 8);
      step();
      en = 4'b0001;
      step();
      en = 4'b0000;
      steps(9);
      check("ch0 drain pattern", hist[0][9:0], 10'b1111000000);
      check("ch0 busy after drain", busy[0], 0);
      en = 4'b0001;
      step();
      en = 4'b0000;
      steps(5);
      en = 4'b0001;
      steps(10);
      check("ch0 reraise pattern", hist[0][15:0], 16'b1111000011110000);
      check("ch0 busy after reraise", busy[0], 1);
      $display("scenario drain done: checks=%0d", checks);

      // Scenario 5: ratio 0 clamps to 2; out-of-range channel ignored.
      en = 4'b0000;
      do_reset();
      write_cfg(2, 0);
      step();
      en = 4'b0100;
      steps(6);
      check("ch2 clamp pattern", hist[2][5:0], 6'b101010);
      write_cfg(7, 3);
      #1;
      check("cfg_ready ch7", cfg_ready, 1);
      steps(5);
      check("ch2 after ch7 write", hist[2][4:0], 5'b10101);
      en = 4'b1100;
      steps(4);
      check("ch3 untouched ratio", hist[3][3:0], 4'b1111);
      $display("scenario clamp done: checks=%0d", checks);

`ifdef CLK_DIV_SYNC_EN
      // Scenario 6: sync aligns channels running at 6 and 9.
      en = 4'b0000;
      do_reset();
      write_cfg(0, 6);
      step();
      write_cfg(1, 9);
      step();
      en = 4'b0011;
      steps(8);
      sync = 1'b1;
      step();
      sync = 1'b0;
      check("sync ticks", tick[1:0], 2'b11);
      check("sync clk_out", clk_out[1:0], 2'b11);
      steps(3);
      $display("scenario sync done: checks=%0d", checks);
`endif

      // Pseudo-random soak with small ratios against the model.
      en = 4'b0000;
      do_reset();
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 15) == 0) begin
            int idx = int'($urandom_range(0, N_CH - 1));
            en[idx] = ~en[idx];
         end
         if (!cfg_valid && $urandom_range(0, 7) == 0)
            write_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 9)));
`ifdef CLK_DIV_SYNC_EN
         sync = ($urandom_range(0, 63) == 0);
`endif
         step();
      end
      $display("scenario soak done: checks=%0d", checks);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
